// File: rtl/rs232_tx_arbiter_if.sv
// rs232_tx_arbiter_if
//   Bundles the requester-side byte streams and the RS-232 transmitter
//   handshake that the arbiter sits between.
//   slave  : the arbiter's view (requests and busy in, ready/strobe/status out)
//   master : the environment's view (requesters plus transmitter)
//   Signals:
//     req_valid/req_data/req_last  N requester byte offers (byte i in [8i+7:8i])
//     req_ready                    one-cycle accept per requester
//     rs232out_busy                transmitter shifting a byte
//     rs232out_w/rs232out_d        write strobe and registered byte
//     grant_id/active/timeout_evt  owner index, lock held, lock dropped by timeout
interface rs232_tx_arbiter_if #(
   parameter int unsigned N = 2
);
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic           rs232out_busy;
   logic           rs232out_w;
   logic [7:0]     rs232out_d;
   logic [2:0]     grant_id;
   logic           active;
   logic           timeout_evt;

   modport slave (
      input  req_valid, req_data, req_last, rs232out_busy,
      output req_ready, rs232out_w, rs232out_d, grant_id, active, timeout_evt
   );

   modport master (
      output req_valid, req_data, req_last, rs232out_busy,
      input  req_ready, rs232out_w, rs232out_d, grant_id, active, timeout_evt
   );
endinterface

// File: rtl/rs232_tx_arbiter.sv
// rs232_tx_arbiter
//   Shares one RS-232 transmitter between N byte-stream requesters.
//   Round-robin arbitration at message granularity: the owner keeps the
//   transmitter until it sends a byte flagged last, or until it has offered
//   nothing for LOCK_TIMEOUT load cycles.
//   Ports:
//     clk  clock
//     rst  synchronous active-high reset
//     bus  rs232_tx_arbiter_if.slave (requesters, transmitter, status)
module rs232_tx_arbiter #(
   parameter int unsigned N            = 2,
   parameter int unsigned LOCK_TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   rs232_tx_arbiter_if.slave bus
);
   typedef enum logic [2:0] {
      ARB   = 3'd0,
      LOAD  = 3'd1,
      SEND  = 3'd2,
      GUARD = 3'd3,
      DRAIN = 3'd4
   } state_t;

   localparam logic [15:0] TIMEOUT_MAX = 16'(LOCK_TIMEOUT);
   localparam logic [2:0]  LAST_IDX    = 3'(N - 1);

   state_t      state_q, state_d;
   logic [2:0]  grant_id_q, grant_id_d;
   logic [2:0]  ptr_q, ptr_d;
   logic [15:0] tmo_cnt_q, tmo_cnt_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        last_q, last_d;

   logic        own_valid, own_last;
   logic [7:0]  own_data;
   logic        found_hi, found_lo, found;
   logic [2:0]  pick_hi, pick_lo, pick;
   logic        accept, expire;
   logic [N-1:0] ready;

   // Current owner's offer.
   always_comb begin
      own_valid = 1'b0;
      own_last  = 1'b0;
      own_data  = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (grant_id_q == 3'(i)) begin
            own_valid = bus.req_valid[i];
            own_last  = bus.req_last[i];
            own_data  = bus.req_data[8*i +: 8];
         end
      end
   end

   // Cyclic search after the pointer: lowest valid index above the pointer
   // wins, otherwise the lowest valid index at or below it.
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      pick_hi  = '0;
      pick_lo  = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (bus.req_valid[i] && (3'(i) > ptr_q) && !found_hi) begin
            found_hi = 1'b1;
            pick_hi  = 3'(i);
         end
         if (bus.req_valid[i] && (3'(i) <= ptr_q) && !found_lo) begin
            found_lo = 1'b1;
            pick_lo  = 3'(i);
         end
      end
      found = found_hi | found_lo;
      pick  = found_hi ? pick_hi : pick_lo;
   end

   // Next state. In LOAD the expired timeout takes precedence, so no byte is
   // accepted in the cycle the lock is dropped.
   always_comb begin
      state_d    = state_q;
      grant_id_d = grant_id_q;
      ptr_d      = ptr_q;
      tmo_cnt_d  = tmo_cnt_q;
      tx_data_d  = tx_data_q;
      last_d     = last_q;
      accept     = 1'b0;
      expire     = 1'b0;
      unique case (state_q)
         ARB: begin
            if (found) begin
               grant_id_d = pick;
               ptr_d      = pick;
               state_d    = LOAD;
            end
         end
         LOAD: begin
            if (tmo_cnt_q >= TIMEOUT_MAX) begin
               expire    = 1'b1;
               tmo_cnt_d = '0;
               state_d   = ARB;
            end else if (own_valid && !bus.rs232out_busy) begin
               accept    = 1'b1;
               tx_data_d = own_data;
               last_d    = own_last;
               tmo_cnt_d = '0;
               state_d   = SEND;
            end else if (!own_valid) begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
         end
         SEND:  state_d = GUARD;
         // busy is not looked at here: the transmitter raises it a cycle late
         GUARD: state_d = DRAIN;
         DRAIN: begin
            if (!bus.rs232out_busy) begin
               state_d = last_q ? ARB : LOAD;
            end
         end
         default: state_d = ARB;
      endcase
   end

   always_comb begin
      ready = '0;
      for (int unsigned i = 0; i < N; i++) begin
         ready[i] = accept && (grant_id_q == 3'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ARB;
         grant_id_q <= '0;
         ptr_q      <= LAST_IDX;
         tmo_cnt_q  <= '0;
         tx_data_q  <= '0;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
         ptr_q      <= ptr_d;
         tmo_cnt_q  <= tmo_cnt_d;
         tx_data_q  <= tx_data_d;
         last_q     <= last_d;
      end
   end

   // Combinational pulses are masked during reset so a reset landing on
   // SEND never strobes the transmitter.
   assign bus.req_ready   = rst ? '0 : ready;
   assign bus.rs232out_w  = (state_q == SEND) && !rst;
   assign bus.timeout_evt = expire && !rst;
   assign bus.rs232out_d  = tx_data_q;
   assign bus.grant_id    = grant_id_q;
   assign bus.active      = (state_q != ARB);
endmodule

// File: tb/tb_rs232_tx_arbiter.sv
`timescale 1ns/1ps
module tb_rs232_tx_arbiter;
   localparam int unsigned N  = 3;
   localparam int unsigned LT = 8;
   localparam int unsigned QD = 256;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rs232_tx_arbiter_if #(.N(N)) bus ();
   rs232_tx_arbiter #(.N(N), .LOCK_TIMEOUT(LT)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;
   int cyc      = 0;

   // requester sources: per-requester byte queues held in arrays
   logic [7:0]  sd [N][QD];
   logic        sl [N][QD];
   int unsigned hd [N];
   int unsigned tl [N];
   int unsigned vprob = 100;

   // transmitter model
   bit          busy_force = 1'b0;
   bit          busy_rand  = 1'b0;
   int unsigned busy_len   = 0;
   int unsigned tx_cnt     = 0;
   bit          rst_drv    = 1'b1;

   // inputs applied this cycle
   logic [N-1:0]   in_valid, in_last;
   logic [8*N-1:0] in_data;
   logic           in_busy, in_rst;

   // reference model: lock owner plus a transfer timeline counted from accept
   bit         m_locked = 1'b0;
   int         m_grant  = 0;
   int         m_ptr    = N - 1;
   int         m_stall  = 0;
   int         m_since  = 0;
   bit         m_tail   = 1'b0;
   bit         m_acc    = 1'b0;
   logic [7:0] m_d      = '0;

   logic [N-1:0] exp_ready;
   logic         exp_w, exp_to, exp_active;
   logic [2:0]   exp_grant;
   logic [7:0]   exp_d;

   // sampled outputs and event logs
   logic [N-1:0] s_ready;
   logic         s_w, s_to, s_active;
   logic [2:0]   s_grant;
   logic [7:0]   s_d;
   int           acc_id[$], acc_cyc[$], acc_gnt[$];
   logic [7:0]   acc_byte[$];
   int           w_cyc[$];
   logic [7:0]   w_byte[$];
   int           to_cyc[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic model_eval();
      bit at_load;
      at_load    = m_locked && (m_since == 0);
      exp_active = m_locked;
      exp_grant  = 3'(m_grant);
      exp_d      = m_d;
      exp_w      = !in_rst && m_locked && (m_since == 1);
      exp_to     = !in_rst && at_load && (m_stall == LT);
      m_acc      = !in_rst && at_load && (m_stall != LT) && in_valid[m_grant] && !in_busy;
      exp_ready  = '0;
      if (m_acc) exp_ready[m_grant] = 1'b1;
   endtask

   // m_since: 0 = waiting to accept, 1 = strobe cycle, 2 = guard, 3 = waiting for idle line
   task automatic model_commit();
      if (in_rst) begin
         m_locked = 1'b0; m_grant = 0; m_ptr = N - 1; m_stall = 0;
         m_since = 0; m_tail = 1'b0; m_d = '0;
      end else if (!m_locked) begin
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (in_valid[c]) begin
               m_grant = c; m_ptr = c; m_locked = 1'b1; m_stall = 0; m_since = 0;
               break;
            end
         end
      end else if (m_since == 0) begin
         if (exp_to) begin
            m_locked = 1'b0; m_stall = 0;
         end else if (m_acc) begin
            m_d = in_data[8*m_grant +: 8]; m_tail = in_last[m_grant];
            m_stall = 0; m_since = 1;
         end else if (!in_valid[m_grant]) begin
            m_stall++;
         end
      end else if (m_since < 3) begin
         m_since++;
      end else if (!in_busy) begin
         m_since = 0;
         if (m_tail) m_locked = 1'b0;
      end
   endtask

   // compare process: every cycle, after inputs and the model have settled
   always begin
      @(negedge clk);
      #3;
      if (chk_en) begin
         chk("req_ready",   32'(bus.req_ready),   32'(exp_ready));
         chk("rs232out_w",  32'(bus.rs232out_w),  32'(exp_w));
         chk("timeout_evt", 32'(bus.timeout_evt), 32'(exp_to));
         chk("active",      32'(bus.active),      32'(exp_active));
         chk("grant_id",    32'(bus.grant_id),    32'(exp_grant));
         chk("rs232out_d",  32'(bus.rs232out_d),  32'(exp_d));
      end
   end

   task automatic step();
      @(negedge clk);
      rst    = rst_drv;
      in_rst = rst_drv;
      for (int i = 0; i < N; i++) begin
         in_valid[i]         = (hd[i] != tl[i]) && ($urandom_range(99) < vprob);
         in_data[8*i +: 8]   = sd[i][hd[i]];
         in_last[i]          = sl[i][hd[i]];
      end
      in_busy           = busy_force || (tx_cnt != 0);
      bus.req_valid     = in_valid;
      bus.req_data      = in_data;
      bus.req_last      = in_last;
      bus.rs232out_busy = in_busy;
      #2;
      model_eval();
      #2;
      s_ready  = bus.req_ready;
      s_w      = bus.rs232out_w;
      s_to     = bus.timeout_evt;
      s_active = bus.active;
      s_grant  = bus.grant_id;
      s_d      = bus.rs232out_d;
      for (int i = 0; i < N; i++) begin
         if (s_ready[i]) begin
            acc_id.push_back(i); acc_cyc.push_back(cyc);
            acc_gnt.push_back(int'(s_grant)); acc_byte.push_back(in_data[8*i +: 8]);
         end
      end
      if (s_w) begin w_cyc.push_back(cyc); w_byte.push_back(s_d); end
      if (s_to) to_cyc.push_back(cyc);
      @(posedge clk);
      model_commit();
      for (int i = 0; i < N; i++) if (s_ready[i] && in_valid[i]) hd[i]++;
      if (s_w) tx_cnt = busy_rand ? $urandom_range(6, 0) : busy_len;
      else if (tx_cnt != 0) tx_cnt--;
      cyc++;
   endtask

   task automatic run(input int unsigned n);
      repeat (n) step();
   endtask

   task automatic push(input int i, input logic [7:0] b, input logic last);
      sd[i][tl[i]] = b; sl[i][tl[i]] = last; tl[i]++;
   endtask

   task automatic wait_acc(input int n, input int unsigned bound, input string nm);
      int unsigned k;
      k = 0;
      while (acc_id.size() < n && k < bound) begin step(); k++; end
      chk(nm, 32'(acc_id.size() >= n), 32'd1);
   endtask

   task automatic dut_reset();
      for (int i = 0; i < N; i++) begin hd[i] = 0; tl[i] = 0; end
      acc_id.delete(); acc_cyc.delete(); acc_gnt.delete(); acc_byte.delete();
      w_cyc.delete(); w_byte.delete(); to_cyc.delete();
      tx_cnt = 0; busy_force = 1'b0; busy_rand = 1'b0; busy_len = 0; vprob = 100;
      rst_drv = 1'b1;
      step();
      rst_drv = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int c0, a, n1;
      int ids1[4] = '{0, 0, 1, 1};
      int ids2[4] = '{1, 1, 0, 0};
      int rr[6]   = '{0, 1, 2, 0, 1, 2};
      logic [7:0] msg[3] = '{8'h41, 8'h42, 8'h0A};

      for (int i = 0; i < N; i++)
         for (int j = 0; j < QD; j++) begin sd[i][j] = '0; sl[i][j] = 1'b0; end

      // reset state
      dut_reset();
      chk_en = 1'b1;
      step();
      chk("reset_ready",  32'(s_ready),  32'd0);
      chk("reset_w",      32'(s_w),      32'd0);
      chk("reset_to",     32'(s_to),     32'd0);
      chk("reset_active", 32'(s_active), 32'd0);
      chk("reset_grant",  32'(s_grant),  32'd0);
      chk("reset_d",      32'(s_d),      32'd0);

      // single message, transmitter busy for 10 cycles after each strobe
      dut_reset();
      busy_len = 10;
      push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h0A, 1'b1);
      c0 = cyc;
      run(60);
      chk("single_w_count", 32'(w_cyc.size()), 32'd3);
      for (int k = 0; k < 3; k++) chk("single_w_byte", 32'(w_byte[k]), 32'(msg[k]));
      chk("single_w0_cycle", 32'(w_cyc[0] - c0), 32'd2);
      chk("single_w1_cycle", 32'(w_cyc[1] - c0), 32'd15);
      chk("single_w2_cycle", 32'(w_cyc[2] - c0), 32'd28);
      for (int k = 1; k < 3; k++) chk("single_gap_ge12", 32'((w_cyc[k] - w_cyc[k-1]) >= 12), 32'd1);
      chk("single_idle_after", 32'(s_active), 32'd0);

      // contention: req0 wins from reset, later req1 wins once req0 held the pointer
      dut_reset();
      push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b1);
      push(1, 8'hB0, 1'b0); push(1, 8'hB1, 1'b1);
      run(30);
      chk("cont1_count", 32'(acc_id.size()), 32'd4);
      for (int k = 0; k < 4; k++) begin
         chk("cont1_owner", 32'(acc_id[k]), 32'(ids1[k]));
         chk("cont1_grant", 32'(acc_gnt[k]), 32'(ids1[k]));
      end
      push(0, 8'hC0, 1'b1);
      run(12);
      push(0, 8'hA2, 1'b0); push(0, 8'hA3, 1'b1);
      push(1, 8'hB2, 1'b0); push(1, 8'hB3, 1'b1);
      run(30);
      chk("cont2_count", 32'(acc_id.size()), 32'd9);
      for (int k = 0; k < 4; k++) chk("cont2_owner", 32'(acc_id[5+k]), 32'(ids2[k]));
      chk("cont2_first_byte", 32'(acc_byte[5]), 32'hB2);

      // round robin, every byte ends a message
      dut_reset();
      for (int i = 0; i < N; i++) for (int j = 0; j < 3; j++) push(i, 8'(16*i + j), 1'b1);
      run(40);
      for (int k = 0; k < 6; k++) chk("rr_order", 32'(acc_id[k]), 32'(rr[k]));

      // timeout: req1 stalls mid-message while req0 waits
      dut_reset();
      push(1, 8'h55, 1'b0);
      wait_acc(1, 10, "to_first_accept");
      a = acc_cyc[0];
      push(0, 8'h66, 1'b1);
      run(25);
      chk("to_count", 32'(to_cyc.size()), 32'd1);
      chk("to_cycle", 32'(to_cyc[0] - a), 32'd12);
      chk("to_next_owner", 32'(acc_id[1]), 32'd0);
      chk("to_next_cycle", 32'(acc_cyc[1] - a), 32'd14);
      n1 = 0;
      for (int k = 1; k < acc_id.size(); k++) if (acc_id[k] == 1) n1++;
      chk("to_no_req1_ready", 32'(n1), 32'd0);

      // busy stall in LOAD
      dut_reset();
      busy_force = 1'b1;
      push(0, 8'h77, 1'b1);
      c0 = cyc;
      run(101);
      busy_force = 1'b0;
      run(8);
      chk("stall_accepts", 32'(acc_id.size()), 32'd1);
      chk("stall_accept_cycle", 32'(acc_cyc[0] - c0), 32'd101);
      chk("stall_no_timeout", 32'(to_cyc.size()), 32'd0);
      chk("stall_w_byte", 32'(w_byte[0]), 32'h77);

      // reset landing on SEND
      dut_reset();
      push(0, 8'h88, 1'b0); push(0, 8'h89, 1'b1);
      wait_acc(1, 10, "rst_first_accept");
      rst_drv = 1'b1;
      step();
      chk("rst_send_w", 32'(s_w), 32'd0);
      rst_drv = 1'b0;
      push(1, 8'h90, 1'b1);
      step();
      chk("rst_after_ready",  32'(s_ready),  32'd0);
      chk("rst_after_w",      32'(s_w),      32'd0);
      chk("rst_after_active", 32'(s_active), 32'd0);
      chk("rst_after_grant",  32'(s_grant),  32'd0);
      chk("rst_after_d",      32'(s_d),      32'd0);
      run(20);
      chk("rst_prio_owner", 32'(acc_id[1]), 32'd0);
      chk("rst_prio_byte",  32'(acc_byte[1]), 32'h89);
      chk("rst_next_owner", 32'(acc_id[2]), 32'd1);
      chk("rst_first_sent", 32'(w_byte[0]), 32'h89);

      // randomized traffic against the model
      dut_reset();
      vprob = 70; busy_rand = 1'b1;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < 150; j++) push(i, 8'($urandom), 1'($urandom_range(3) == 0));
      for (int k = 0; k < 3000; k++) begin
         rst_drv = ($urandom_range(499) == 0);
         step();
      end
      rst_drv = 1'b0;
      step();
      chk("random_traffic", 32'(w_cyc.size() > 100), 32'd1);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
